mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit implementing the RISC-V M-extension operations, parametrised in operand width. It runs beside the single-cycle ALU in the execute stage and shares its operand naming (SrcA, SrcB), result naming (ALUResult) and zero flag. Operations take a fixed multi-cycle latency under a Start/Busy/Done handshake, and a Kill input lets the pipeline abort an operation on flush.

## Interface
- WIDTH, default 32: operand and result width in bits; WIDTH ≥ 4.
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- Start  in  1  request to begin an operation; accepted only in IDLE.
- Kill  in  1  abort the in-flight operation (pipeline flush).
- MulDivOp  in  3  operation select, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  WIDTH  multiplicand or dividend.
- SrcB  in  WIDTH  multiplier or divisor.
- Busy  out  1  operation in progress; Start is ignored while high.
- Done  out  1  one-cycle pulse; ALUResult is valid in this cycle.
- ALUResult  out  WIDTH  registered result; holds its value until the next Done.
- Zero  out  1  registered; equals (ALUResult == 0) and updates together with ALUResult.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, with Start=1 and Kill=0:
  - Latch MulDivOp and the sign flags.
  - Latch |SrcA| and |SrcB| for the signed operand positions (MULH both, MULHSU SrcA only, DIV and REM both); latch raw values for unsigned positions.
  - Clear the 2·WIDTH accumulator, load iteration counter = WIDTH−1, go to CALC.
- CALC: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle, WIDTH cycles. Decrement the counter each step; after the step taken with counter = 0, go to FIX.
- FIX: negate the product when the operand signs differ. Negate the quotient when the dividend and divisor signs differ. Negate the remainder when the dividend is negative. Then select the result:
  - MUL: low WIDTH bits of the product.
  - MULH, MULHSU, MULHU: high WIDTH bits of the product.
  - DIV, DIVU: quotient. REM, REMU: remainder.
- FIX registers ALUResult and Zero, pulses Done, and returns to IDLE.
- Division by zero: quotient = all ones (signed and unsigned); remainder = SrcA. Uses the same latency as any other operation.
- Signed overflow (SrcA = most-negative, SrcB = −1, DIV or REM): quotient = SrcA, remainder = 0, same latency.
- Arithmetic is two's complement, modulo 2^WIDTH. The most-negative operand's magnitude is handled as an unsigned WIDTH-bit value (no extra bit is needed).
- Kill in CALC or FIX: go to IDLE on the next edge. No Done pulse; ALUResult and Zero are not updated.
- Kill and Start together in IDLE: Kill wins and the operation is not accepted.
- Kill in IDLE alone: no effect.
- Start while Busy=1: ignored and not queued.

## Timing
- Reset (reset_n low at an edge): state IDLE, Busy=0, Done=0, ALUResult=0, Zero=1, counter=0. Reset mid-operation aborts it with no Done pulse.
- Start sampled high in cycle 0:
  - Busy is high in cycles 1 through WIDTH+1.
  - Done is high in cycle WIDTH+2 only, with Busy=0 in that cycle.
- Total latency is WIDTH+2 cycles and is independent of operation and operand values.
- Back-to-back operation: Start is accepted in the Done cycle. The next Done then follows WIDTH+2 cycles later, giving a throughput of one operation per WIDTH+2 cycles.
- Operand inputs are sampled only at the accepting edge; later changes to SrcA, SrcB or MulDivOp have no effect on the operation in flight.
- Kill asserted in cycle n (1 ≤ n ≤ WIDTH+1) gives Busy=0 from cycle n+1. A Start in cycle n+1 is accepted.
- Done is never asserted in the same cycle as Busy.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD (WIDTH=32) -> Done in cycle 34, ALUResult=0xFFFFFFEB, Zero=0, Busy high in cycles 1–33 only.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD and REM −7%2 -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF and REMU 5%0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0 with Zero=1. Every case has latency 34.
- Back-to-back: MUL 3×4 started in cycle 0, then DIVU 100/7 started in the Done cycle (cycle 34) -> Done in cycle 34 with 12, Done in cycle 68 with 14. A Start pulsed in cycle 10 with different operands is ignored.
- Kill in cycle 15 of a DIV -> Busy=0 from cycle 16, no Done pulse, ALUResult keeps its previous value. Kill and Start together in IDLE -> no operation starts.
- reset_n low in cycle 20 of a MUL -> Busy=0, Done=0, ALUResult=0, Zero=1 after the edge. Repeat all arithmetic cases with WIDTH=8 (e.g. DIV 0x80/0xFF -> 0x80, latency 10).

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with Start/Busy/Done handshake.
// Fixed latency of WIDTH+2 cycles: WIDTH shift steps, one fix-up cycle, one Done cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic             Kill,
  input  logic [2:0]       MulDivOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               sign_a, sign_b;
  logic [WIDTH+1:0]   diff;
  logic               restore;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_f, rem_f;

  // Signed operand positions: MULH both, MULHSU SrcA only, DIV/REM both.
  assign sign_a = MulDivOp[2] ? ~MulDivOp[0] : (MulDivOp[1:0] == 2'b01 || MulDivOp[1:0] == 2'b10);
  assign sign_b = MulDivOp[2] ? ~MulDivOp[0] : (MulDivOp[1:0] == 2'b01);

  // Restoring divide trial subtract; partial remainder lives in the upper half of acc.
  assign diff    = {1'b0, acc_q[2*WIDTH-1:WIDTH], a_q[cnt_q]} - {2'b00, b_q};
  // A successful subtract always leaves diff < b, so bit WIDTH is only set on a borrow.
  assign restore = diff[WIDTH+1] | diff[WIDTH];

  // Sign fix-up of the unsigned magnitude results.
  assign prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_f = (b_q == '0) ? '1 :
                 ((neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_f = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start && !Kill) begin
          op_d    = MulDivOp;
          neg_a_d = sign_a & SrcA[WIDTH-1];
          neg_b_d = sign_b & SrcB[WIDTH-1];
          a_d     = (sign_a & SrcA[WIDTH-1]) ? -SrcA : SrcA;
          b_d     = (sign_b & SrcB[WIDTH-1]) ? -SrcB : SrcB;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (Kill) begin
          state_d = StIdle;
        end else begin
          if (!op_q[2]) begin
            // MSB-first shift-add multiply.
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0} + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} : '0);
          end else if (!restore) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:WIDTH], a_q[cnt_q], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!Kill) begin
          case (op_q)
            3'b000:                 result_d = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         result_d = quo_f;
            default:                result_d = rem_f;
          endcase
          zero_d = (result_d == '0);
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = (state_q != StIdle);
  assign Done      = done_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule
